// File: rtl/sub_16_serial.sv
// Slice-serial subtractor D = A - B - BIN, SLICE bits per clock with a registered borrow.
// start/busy/done handshake; D, BOUT, zero and ovf update only when the last slice completes.
module sub_16_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BIN,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             BOUT,
   output logic             zero,
   output logic             ovf
);

   localparam int N     = WIDTH / SLICE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                 state;
   logic [WIDTH-1:0]       a_reg;
   logic [WIDTH-1:0]       b_reg;
   logic [WIDTH-1:0]       work;
   logic                   borrow;
   logic                   a_msb;
   logic                   b_msb;
   logic [CNT_W-1:0]       cnt;

   logic [SLICE:0]         slice_res;
   logic [WIDTH-1:0]       work_next;

   // Top bit of the (SLICE+1)-bit difference is the borrow out of the slice.
   function automatic logic [SLICE:0] slice_sub(input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b,
                                                input logic             bin);
      return {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
   endfunction

   // Operands shift right one slice per clock; each new diff enters the working
   // register from the top, so after N slices it holds the result in order.
   always_comb begin
      slice_res = slice_sub(a_reg[SLICE-1:0], b_reg[SLICE-1:0], borrow);
      work_next = {slice_res[SLICE-1:0], work[WIDTH-1:SLICE]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_reg  <= '0;
         b_reg  <= '0;
         work   <= '0;
         borrow <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         D      <= '0;
         BOUT   <= 1'b0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE, FINISH: begin
               done <= 1'b0;
               if (start) begin
                  a_reg  <= A;
                  b_reg  <= B;
                  borrow <= BIN;
                  a_msb  <= A[WIDTH-1];
                  b_msb  <= B[WIDTH-1];
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               a_reg  <= a_reg >> SLICE;
               b_reg  <= b_reg >> SLICE;
               work   <= work_next;
               borrow <= slice_res[SLICE];
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_W'(N - 1)) begin
                  D     <= work_next;
                  BOUT  <= slice_res[SLICE];
                  zero  <= (work_next == '0);
                  ovf   <= (a_msb != b_msb) && (work_next[WIDTH-1] != a_msb);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FINISH;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
